pipeid: RTL and testbench
=========================

Name: pipeid

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline.
- Decodes the IF/ID instruction and reads the 32x32 register file, which it owns and which the WB stage writes.
- Computes branch and jump targets and next-PC select.
- Detects load-use hazards and produces forwarding selects for the EXE-stage operand muxes.
- Sits between the IF/ID and ID/EXE pipeline registers; everything except the register file is combinational.

Parameters:
- none

Ports:
- clk  in  1  clock; register file writes on rising edge.
- clrn  in  1  synchronous reset, active-high (1 = reset) despite the name.
- dpc4  in  32  PC+4 of the ID instruction.
- inst  in  32  ID instruction.
- wrn  in  5  WB destination register.
- wdi  in  32  WB write data.
- wwreg  in  1  WB write enable.
- rsrtequ  in  1  external comparison: forwarded rs value equals forwarded rt value.
- em2reg  in  1  EXE instruction is a load.
- ern  in  5  EXE destination register.
- ewreg  in  1  EXE writes a register.
- mwreg  in  1  MEM writes a register.
- mrn  in  5  MEM destination register.
- bpc  out  32  branch target.
- jpc  out  32  jump target.
- pcsource  out  2  next-PC select.
- wreg  out  1  register write enable.
- m2reg  out  1  write back from memory.
- wmem  out  1  store.
- aluc  out  5  ALU operation.
- aluimm  out  1  ALU B operand is imm.
- a  out  32  rs value.
- b  out  32  rt value.
- imm  out  32  extended immediate.
- rn  out  5  destination register.
- shift  out  1  ALU A operand is sa = inst[10:6].
- jal  out  1  jal instruction.
- load_depen  out  1  load-use stall.
- a_depen  out  2  rs forward select.
- b_depen  out  2  rt forward select.

Behaviour:
- Supported instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, jr.
  - I-type: addi, andi, ori, xori, lw, sw, beq, bne, lui.
  - J-type: j, jal.
  - Any other encoding: all controls 0, pcsource 00, aluc 00000.
- aluc codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, LUI 00101, SLL 00110, SRL 00111, SRA 01000.
  - addi, lw, sw use ADD; andi/ori/xori use AND/OR/XOR.
- Register file:
  - r0 always reads 0.
  - Write at posedge clk when wwreg & wrn!=0 & !clrn.
  - Synchronous reset clears all 32 registers.
- Read bypass: if wwreg & wrn!=0 & wrn==rs, then a=wdi; same rule for rt and b. Bypass is disabled while clrn=1.
- imm: zero-extended inst[15:0] for andi/ori/xori; sign-extended otherwise.
- bpc = dpc4 + (sign-extended inst[15:0] << 2), modulo 2^32.
- jpc = {dpc4[31:28], inst[25:0], 2'b00}.
- rn:
  - rd for R-type.
  - rt for I-type writers.
  - 31 for jal.
- wreg is 1 for: R-type arithmetic/shift, addi, andi, ori, xori, lw, lui, jal.
- aluimm is 1 for: addi, andi, ori, xori, lw, sw, lui.
- m2reg = lw; wmem = sw; shift = sll|srl|sra; jal = jal.
- pcsource:
  - 01 for beq when rsrtequ=1, and for bne when rsrtequ=0.
  - 10 for jr.
  - 11 for j and jal.
  - 00 otherwise.
- load_depen = ewreg & em2reg & ern!=0 & ((ern==rs & uses_rs) | (ern==rt & uses_rt)).
  - uses_rs: all instructions except sll/srl/sra, lui, j, jal.
  - uses_rt: R-type arithmetic/shift, sw, beq, bne.
- While load_depen=1: wreg, wmem forced 0 and pcsource forced 00 (bubble). The IF/ID hold is done outside this block using load_depen.
- a_depen (rs operand):
  - 01 when ewreg & ern!=0 & ern==rs & !em2reg.
  - Else 10 when mwreg & mrn!=0 & mrn==rs.
  - Else 00.
  - 11 never produced. EXE takes priority over MEM.
- b_depen: same rules against rt.
- During reset: a=b=0; combinational outputs still follow inst.

Decomposition:
- Shared package holds:
  - opcode and funct constants;
  - aluc codes;
  - pcsource codes (PC4, BR, JR, JMP);
  - forward-select codes (REG 00, EXE 01, MEM 10).
- One sub-module: pipeid_regfile (32x32, 2 read ports, 1 write port, synchronous reset, r0=0, write bypass).

Test Plan:
- Reset, then clrn=0, then write r5=0x1234 via wwreg/wrn/wdi; next cycle inst=add r3,r5,r0 -> a=0x1234, b=0, rn=3, wreg=1, aluc=00000.
- Same-cycle write/read: wwreg=1, wrn=7, wdi=0xDEADBEEF, inst reads rs=7 -> a=0xDEADBEEF. Writing r0 -> a stays 0.
- beq with dpc4=0x100, imm=0xFFFF -> bpc=0x0FC; pcsource=01 when rsrtequ=1, 00 when rsrtequ=0. bne gives the inverse. j 0x0000010 with dpc4=0x10000004 -> jpc=0x10000040, pcsource=11.
- Load-use: ewreg=1, em2reg=1, ern=4, inst=add r2,r4,r1 -> load_depen=1, wreg=0. sll r2,r4,2 with ern=4 (rt=4) -> stall. inst=lui r2 with rs field=4 -> no stall.
- Forwarding: ewreg=1, em2reg=0, ern=3, mwreg=1, mrn=3, inst rs=3, rt=3 -> a_depen=01, b_depen=01. Set ewreg=0 -> a_depen=10, b_depen=10. ern=mrn=0 -> 00.
- Immediates: ori 0x8000 -> imm=0x00008000, aluimm=1. addi 0x8000 -> imm=0xFFFF8000. jal -> rn=31, jal=1, wreg=1.

Source files
------------

// File: rtl/pipeid_pkg.sv
// Shared decode constants for the ID stage: opcodes, funct codes, ALU ops, PC and forward selects.
// No logic; a single helper picks the EXE/MEM forwarding source for one operand.
// Backpressure: n/a.
package pipeid_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_XOR = 5'b00100,
        ALU_LUI = 5'b00101,
        ALU_SLL = 5'b00110,
        ALU_SRL = 5'b00111,
        ALU_SRA = 5'b01000
    } aluc_e;

    typedef enum logic [1:0] {
        PC_PC4 = 2'b00,
        PC_BR  = 2'b01,
        PC_JR  = 2'b10,
        PC_JMP = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EXE = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // A load in EXE has no result yet, so it never forwards from EXE; load_depen stalls instead.
    function automatic fwd_e fwd_sel(input logic ewreg, input logic em2reg, input logic [4:0] ern,
                                     input logic mwreg, input logic [4:0] mrn, input logic [4:0] src);
        if (ewreg && ern != 5'd0 && ern == src && !em2reg)
            return FWD_EXE;
        else if (mwreg && mrn != 5'd0 && mrn == src)
            return FWD_MEM;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeid_if.sv
// ID-stage bundle: IF/ID and WB/EXE/MEM inputs in, ID/EXE controls and operands out.
// Combinational across the bundle; the register file is the only state behind it.
// Backpressure: none on the bundle; load_depen is the stall indication.
interface pipeid_if;
    logic [31:0] dpc4;
    logic [31:0] inst;
    logic [4:0]  wrn;
    logic [31:0] wdi;
    logic        wwreg;
    logic        rsrtequ;
    logic        em2reg;
    logic [4:0]  ern;
    logic        ewreg;
    logic        mwreg;
    logic [4:0]  mrn;

    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [1:0]  pcsource;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [4:0]  aluc;
    logic        aluimm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rn;
    logic        shift;
    logic        jal;
    logic        load_depen;
    logic [1:0]  a_depen;
    logic [1:0]  b_depen;

    modport master (
        output dpc4, inst, wrn, wdi, wwreg, rsrtequ, em2reg, ern, ewreg, mwreg, mrn,
        input  bpc, jpc, pcsource, wreg, m2reg, wmem, aluc, aluimm, a, b, imm, rn,
               shift, jal, load_depen, a_depen, b_depen
    );

    modport slave (
        input  dpc4, inst, wrn, wdi, wwreg, rsrtequ, em2reg, ern, ewreg, mwreg, mrn,
        output bpc, jpc, pcsource, wreg, m2reg, wmem, aluc, aluimm, a, b, imm, rn,
               shift, jal, load_depen, a_depen, b_depen
    );
endinterface

// File: rtl/pipeid_regfile.sv
// 32x32 register file, two read ports, one write port, r0 hard zero, write-through bypass.
// Reads are combinational; writes land on the rising edge of clk.
// Backpressure: none; reads return 0 while clrn is high.
module pipeid_regfile (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    input  logic [4:0]  wn,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] qa,
    output logic [31:0] qb
);
    logic [31:0] regs [32];
    logic        wr_en;

    assign wr_en = we && (wn != 5'd0);

    always_ff @(posedge clk) begin
        if (clrn) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wn] <= d;
        end
    end

    // WB result written this cycle is visible to ID in the same cycle.
    assign qa = clrn                      ? '0 :
                (wr_en && wn == rna)      ? d  :
                (rna == 5'd0)             ? '0 : regs[rna];
    assign qb = clrn                      ? '0 :
                (wr_en && wn == rnb)      ? d  :
                (rnb == 5'd0)             ? '0 : regs[rnb];
endmodule

// File: rtl/pipeid.sv
// MIPS ID stage: decode, register read, branch/jump targets, load-use stall and forward selects.
// Zero-cycle combinational path from inst to all outputs; register file writes on clk.
// Backpressure: load_depen turns the current instruction into a bubble; IF/ID hold is external.
module pipeid
    import pipeid_pkg::*;
(
    input  logic     clk,
    input  logic     clrn,
    pipeid_if.slave  p
);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;

    assign op = p.inst[31:26];
    assign fn = p.inst[5:0];
    assign rs = p.inst[25:21];
    assign rt = p.inst[20:16];
    assign rd = p.inst[15:11];

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;

    assign r_type = (op == OP_RTYPE);
    assign i_add  = r_type && fn == FN_ADD;
    assign i_sub  = r_type && fn == FN_SUB;
    assign i_and  = r_type && fn == FN_AND;
    assign i_or   = r_type && fn == FN_OR;
    assign i_xor  = r_type && fn == FN_XOR;
    assign i_sll  = r_type && fn == FN_SLL;
    assign i_srl  = r_type && fn == FN_SRL;
    assign i_sra  = r_type && fn == FN_SRA;
    assign i_jr   = r_type && fn == FN_JR;
    assign i_addi = (op == OP_ADDI);
    assign i_andi = (op == OP_ANDI);
    assign i_ori  = (op == OP_ORI);
    assign i_xori = (op == OP_XORI);
    assign i_lw   = (op == OP_LW);
    assign i_sw   = (op == OP_SW);
    assign i_beq  = (op == OP_BEQ);
    assign i_bne  = (op == OP_BNE);
    assign i_lui  = (op == OP_LUI);
    assign i_j    = (op == OP_J);
    assign i_jal  = (op == OP_JAL);

    logic r_alu, r_shift, i_logic_imm;
    logic wreg_raw, uses_rs, uses_rt, stall;
    aluc_e  aluc;
    pcsrc_e pcsrc_raw;

    assign r_alu       = i_add | i_sub | i_and | i_or | i_xor;
    assign r_shift     = i_sll | i_srl | i_sra;
    assign i_logic_imm = i_andi | i_ori | i_xori;

    assign wreg_raw = r_alu | r_shift | i_addi | i_logic_imm | i_lw | i_lui | i_jal;
    assign uses_rs  = r_alu | i_jr | i_addi | i_logic_imm | i_lw | i_sw | i_beq | i_bne;
    assign uses_rt  = r_alu | r_shift | i_sw | i_beq | i_bne;

    always_comb begin
        aluc = ALU_ADD;
        if (i_sub)                         aluc = ALU_SUB;
        else if (i_and || i_andi)          aluc = ALU_AND;
        else if (i_or  || i_ori)           aluc = ALU_OR;
        else if (i_xor || i_xori)          aluc = ALU_XOR;
        else if (i_lui)                    aluc = ALU_LUI;
        else if (i_sll)                    aluc = ALU_SLL;
        else if (i_srl)                    aluc = ALU_SRL;
        else if (i_sra)                    aluc = ALU_SRA;
    end

    always_comb begin
        pcsrc_raw = PC_PC4;
        if ((i_beq && p.rsrtequ) || (i_bne && !p.rsrtequ)) pcsrc_raw = PC_BR;
        else if (i_jr)                                     pcsrc_raw = PC_JR;
        else if (i_j || i_jal)                             pcsrc_raw = PC_JMP;
    end

    assign stall = p.ewreg && p.em2reg && (p.ern != 5'd0) &&
                   ((p.ern == rs && uses_rs) || (p.ern == rt && uses_rt));

    // A stalled instruction must not commit state or redirect fetch.
    assign p.load_depen = stall;
    assign p.wreg       = wreg_raw && !stall;
    assign p.wmem       = i_sw && !stall;
    assign p.pcsource   = stall ? PC_PC4 : pcsrc_raw;
    assign p.m2reg      = i_lw;
    assign p.aluimm     = i_addi | i_logic_imm | i_lw | i_sw | i_lui;
    assign p.shift      = r_shift;
    assign p.jal        = i_jal;
    assign p.aluc       = aluc;

    logic [31:0] imm_sext;
    assign imm_sext = {{16{p.inst[15]}}, p.inst[15:0]};

    assign p.imm = i_logic_imm ? {16'h0000, p.inst[15:0]} : imm_sext;
    assign p.bpc = p.dpc4 + {imm_sext[29:0], 2'b00};
    assign p.jpc = {p.dpc4[31:28], p.inst[25:0], 2'b00};
    assign p.rn  = i_jal ? 5'd31 : (r_type ? rd : rt);

    assign p.a_depen = fwd_sel(p.ewreg, p.em2reg, p.ern, p.mwreg, p.mrn, rs);
    assign p.b_depen = fwd_sel(p.ewreg, p.em2reg, p.ern, p.mwreg, p.mrn, rt);

    pipeid_regfile u_regfile (
        .clk  (clk),
        .clrn (clrn),
        .rna  (rs),
        .rnb  (rt),
        .wn   (p.wrn),
        .d    (p.wdi),
        .we   (p.wwreg),
        .qa   (p.a),
        .qb   (p.b)
    );
endmodule

// File: tb/tb_pipeid.sv
// Directed bench for pipeid: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeid;
    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    pipeid_if bus();

    pipeid dut (
        .clk  (clk),
        .clrn (clrn),
        .p    (bus)
    );

    localparam int F_A = 0, F_B = 1, F_BPC = 2, F_JPC = 3, F_PCS = 4, F_WREG = 5, F_M2R = 6,
                   F_WMEM = 7, F_ALUC = 8, F_ALUIMM = 9, F_IMM = 10, F_RN = 11, F_SHIFT = 12,
                   F_JAL = 13, F_LD = 14, F_AD = 15, F_BD = 16;

    typedef struct {
        int          vec;
        int          fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vec_id = 0;
    int   tests  = 0;
    int   fails  = 0;

    function automatic logic [31:0] get_fld(input int f);
        case (f)
            F_A:      return bus.a;
            F_B:      return bus.b;
            F_BPC:    return bus.bpc;
            F_JPC:    return bus.jpc;
            F_PCS:    return {30'd0, bus.pcsource};
            F_WREG:   return {31'd0, bus.wreg};
            F_M2R:    return {31'd0, bus.m2reg};
            F_WMEM:   return {31'd0, bus.wmem};
            F_ALUC:   return {27'd0, bus.aluc};
            F_ALUIMM: return {31'd0, bus.aluimm};
            F_IMM:    return bus.imm;
            F_RN:     return {27'd0, bus.rn};
            F_SHIFT:  return {31'd0, bus.shift};
            F_JAL:    return {31'd0, bus.jal};
            F_LD:     return {31'd0, bus.load_depen};
            F_AD:     return {30'd0, bus.a_depen};
            F_BD:     return {30'd0, bus.b_depen};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic string fld_name(input int f);
        case (f)
            F_A: return "a";            F_B: return "b";          F_BPC: return "bpc";
            F_JPC: return "jpc";        F_PCS: return "pcsource"; F_WREG: return "wreg";
            F_M2R: return "m2reg";      F_WMEM: return "wmem";    F_ALUC: return "aluc";
            F_ALUIMM: return "aluimm";  F_IMM: return "imm";      F_RN: return "rn";
            F_SHIFT: return "shift";    F_JAL: return "jal";      F_LD: return "load_depen";
            F_AD: return "a_depen";     F_BD: return "b_depen";
            default: return "?";
        endcase
    endfunction

    task automatic ex(input int f, input logic [31:0] v);
        exp_t e;
        e.vec = vec_id;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic idle_in();
        clrn        = 1'b0;
        bus.dpc4    = '0;
        bus.inst    = '0;
        bus.wrn     = '0;
        bus.wdi     = '0;
        bus.wwreg   = 1'b0;
        bus.rsrtequ = 1'b0;
        bus.em2reg  = 1'b0;
        bus.ern     = '0;
        bus.ewreg   = 1'b0;
        bus.mwreg   = 1'b0;
        bus.mrn     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        vec_id++;
    endtask

    // Monitor: compare every expectation tagged with the vector currently on the bus.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].vec <= vec_id) begin
            e   = sb.pop_front();
            got = get_fld(e.fld);
            tests++;
            if (e.vec < vec_id) begin
                fails++;
                $display("FAIL vec%0d %s: expectation never sampled (required %h)",
                         e.vec, fld_name(e.fld), e.val);
            end else if (got !== e.val) begin
                fails++;
                $display("FAIL vec%0d %s: got %h, required %h",
                         e.vec, fld_name(e.fld), got, e.val);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : driver
        idle_in();
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // Reset: reads forced to 0 even with a WB write pending; decode still follows inst.
        idle_in(); clrn = 1'b1;
        bus.wwreg = 1'b1; bus.wrn = 5'd5; bus.wdi = 32'h1234; bus.inst = 32'h00A01820;
        ex(F_A, 32'h0); ex(F_B, 32'h0); ex(F_RN, 32'd3); ex(F_WREG, 32'd1);
        tick();

        // Write r5 = 0x1234 under a nop.
        idle_in();
        bus.wwreg = 1'b1; bus.wrn = 5'd5; bus.wdi = 32'h1234;
        ex(F_A, 32'h0); ex(F_RN, 32'd0);
        tick();

        // add r3,r5,r0
        idle_in(); bus.inst = 32'h00A01820;
        ex(F_A, 32'h1234); ex(F_B, 32'h0); ex(F_RN, 32'd3); ex(F_WREG, 32'd1);
        ex(F_ALUC, 32'h0); ex(F_ALUIMM, 32'd0); ex(F_LD, 32'd0);
        tick();

        // Same-cycle write of r7 bypasses to rs; add r1,r7,r5
        idle_in(); bus.inst = 32'h00E50820;
        bus.wwreg = 1'b1; bus.wrn = 5'd7; bus.wdi = 32'hDEADBEEF;
        ex(F_A, 32'hDEADBEEF); ex(F_B, 32'h1234); ex(F_RN, 32'd1);
        tick();

        idle_in(); bus.inst = 32'h00E50820;
        ex(F_A, 32'hDEADBEEF);
        tick();

        // Writing r0 must not bypass nor stick: add r1,r0,r7
        idle_in(); bus.inst = 32'h00070820;
        bus.wwreg = 1'b1; bus.wrn = 5'd0; bus.wdi = 32'hFFFFFFFF;
        ex(F_A, 32'h0); ex(F_B, 32'hDEADBEEF);
        tick();

        idle_in(); bus.inst = 32'h00000820;
        ex(F_A, 32'h0); ex(F_B, 32'h0);
        tick();

        // beq r1,r2,-1 at dpc4=0x100
        idle_in(); bus.inst = 32'h1022FFFF; bus.dpc4 = 32'h100; bus.rsrtequ = 1'b1;
        ex(F_BPC, 32'h0FC); ex(F_PCS, 32'd1); ex(F_WREG, 32'd0); ex(F_IMM, 32'hFFFFFFFF);
        ex(F_ALUIMM, 32'd0);
        tick();

        idle_in(); bus.inst = 32'h1022FFFF; bus.dpc4 = 32'h100; bus.rsrtequ = 1'b0;
        ex(F_BPC, 32'h0FC); ex(F_PCS, 32'd0);
        tick();

        // bne inverts the taken condition
        idle_in(); bus.inst = 32'h1422FFFF; bus.dpc4 = 32'h100; bus.rsrtequ = 1'b0;
        ex(F_PCS, 32'd1); ex(F_BPC, 32'h0FC);
        tick();

        idle_in(); bus.inst = 32'h1422FFFF; bus.dpc4 = 32'h100; bus.rsrtequ = 1'b1;
        ex(F_PCS, 32'd0);
        tick();

        // j 0x0000010
        idle_in(); bus.inst = 32'h08000010; bus.dpc4 = 32'h10000004;
        ex(F_JPC, 32'h10000040); ex(F_PCS, 32'd3); ex(F_WREG, 32'd0); ex(F_JAL, 32'd0);
        tick();

        // Load-use on rs: add r2,r4,r1 behind lw r4
        idle_in(); bus.inst = 32'h00811020;
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd4;
        ex(F_LD, 32'd1); ex(F_WREG, 32'd0); ex(F_AD, 32'd0); ex(F_RN, 32'd2);
        tick();

        // Load-use on rt: sll r2,r4,2
        idle_in(); bus.inst = 32'h00041080;
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd4;
        ex(F_LD, 32'd1); ex(F_WREG, 32'd0); ex(F_SHIFT, 32'd1); ex(F_ALUC, 32'b00110);
        tick();

        // lui ignores rs: no stall
        idle_in(); bus.inst = 32'h3C821234;
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd4;
        ex(F_LD, 32'd0); ex(F_WREG, 32'd1); ex(F_RN, 32'd2); ex(F_ALUC, 32'b00101);
        ex(F_ALUIMM, 32'd1); ex(F_IMM, 32'h1234);
        tick();

        // Forwarding: EXE beats MEM
        idle_in(); bus.inst = 32'h00630820;
        bus.ewreg = 1'b1; bus.ern = 5'd3; bus.mwreg = 1'b1; bus.mrn = 5'd3;
        ex(F_AD, 32'd1); ex(F_BD, 32'd1); ex(F_LD, 32'd0);
        tick();

        idle_in(); bus.inst = 32'h00630820;
        bus.ewreg = 1'b0; bus.ern = 5'd3; bus.mwreg = 1'b1; bus.mrn = 5'd3;
        ex(F_AD, 32'd2); ex(F_BD, 32'd2);
        tick();

        idle_in(); bus.inst = 32'h00630820;
        bus.ewreg = 1'b1; bus.ern = 5'd0; bus.mwreg = 1'b1; bus.mrn = 5'd0;
        ex(F_AD, 32'd0); ex(F_BD, 32'd0);
        tick();

        // ori zero-extends
        idle_in(); bus.inst = 32'h34028000;
        ex(F_IMM, 32'h00008000); ex(F_ALUIMM, 32'd1); ex(F_ALUC, 32'b00011);
        ex(F_RN, 32'd2); ex(F_WREG, 32'd1);
        tick();

        // addi sign-extends
        idle_in(); bus.inst = 32'h20028000;
        ex(F_IMM, 32'hFFFF8000); ex(F_ALUC, 32'h0); ex(F_ALUIMM, 32'd1);
        tick();

        // jal
        idle_in(); bus.inst = 32'h0C000010; bus.dpc4 = 32'h10000004;
        ex(F_RN, 32'd31); ex(F_JAL, 32'd1); ex(F_WREG, 32'd1); ex(F_PCS, 32'd3);
        ex(F_JPC, 32'h10000040);
        tick();

        // sw r5,4(r0)
        idle_in(); bus.inst = 32'hAC050004;
        ex(F_WMEM, 32'd1); ex(F_WREG, 32'd0); ex(F_ALUIMM, 32'd1); ex(F_IMM, 32'd4);
        ex(F_B, 32'h1234); ex(F_M2R, 32'd0);
        tick();

        // sw behind lw r5: bubble suppresses the store
        idle_in(); bus.inst = 32'hAC050004;
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd5;
        ex(F_LD, 32'd1); ex(F_WMEM, 32'd0);
        tick();

        // lw r3,8(r0)
        idle_in(); bus.inst = 32'h8C030008;
        ex(F_M2R, 32'd1); ex(F_WREG, 32'd1); ex(F_RN, 32'd3); ex(F_ALUC, 32'h0);
        tick();

        // Unsupported opcode: all controls quiet
        idle_in(); bus.inst = 32'hFC000000;
        ex(F_WREG, 32'd0); ex(F_ALUC, 32'h0); ex(F_PCS, 32'd0); ex(F_ALUIMM, 32'd0);
        ex(F_WMEM, 32'd0);
        tick();

        // jr r7
        idle_in(); bus.inst = 32'h00E00008;
        ex(F_PCS, 32'd2); ex(F_A, 32'hDEADBEEF); ex(F_WREG, 32'd0);
        tick();

        // jr is bubbled by a pending load into rs
        idle_in(); bus.inst = 32'h00E00008;
        bus.ewreg = 1'b1; bus.em2reg = 1'b1; bus.ern = 5'd7;
        ex(F_LD, 32'd1); ex(F_PCS, 32'd0);
        tick();

        // Synchronous reset clears the register file
        idle_in(); clrn = 1'b1; bus.inst = 32'h00A01820;
        ex(F_A, 32'h0);
        tick();

        idle_in(); bus.inst = 32'h00E50820;
        ex(F_A, 32'h0); ex(F_B, 32'h0);
        tick();

        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL vec%0d %s: expectation never sampled (required %h)",
                     e.vec, fld_name(e.fld), e.val);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
